blood_parent_entry: RTL and testbench
=====================================

Name: blood_parent_entry

Overview:
- Front-end input stage for the blood-type calculator.
- Synchronises and debounces the two board switches and two keys, and turns each debounced switch rising edge into a one-shot capture of the current key pattern into the Father/Mother registers.
- Tracks entry progress with a small FSM.
- Its Father/Mother/valid outputs drive the blood-type calculation stage and the LED display directly, so no raw switch is ever used as a clock.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles an input must hold a new level before it is accepted (10 ms at 50 MHz); minimum 2
CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
Sys_CLK  input  1  system clock, all logic on rising edge
Sys_RST  input  1  reset, asynchronous, active-high
Switch  input  2  raw slide switches; [1] = father capture, [0] = mother capture
Key  input  2  raw keys; [1] = A antigen, [0] = B antigen
Key_Stable  output  2  debounced key levels
Father  output  2  captured father type
Mother  output  2  captured mother type
Father_Valid  output  1  father captured at least once since reset
Mother_Valid  output  1  mother captured at least once since reset
Both_Valid  output  1  FSM in COMPLETE
Update  output  1  one-cycle pulse whenever Father or Mother is written

Behaviour:
- Reset (async, active-high):
  - All outputs, synchroniser flops, debounce counters and stable levels go to 0.
  - FSM goes to EMPTY.
- Synchroniser: each of the 4 raw bits passes through a 2-flop synchroniser.
- Debounce, per bit:
  - If synced == stable: counter clears to 0.
  - Otherwise the counter increments. When it equals DEBOUNCE_CYCLES-1 and synced still differs, stable <= synced on that edge and the counter clears.
  - Any bounce back to the stable level clears the counter.
- Latency: a clean raw transition reaches the stable level 2 + DEBOUNCE_CYCLES cycles after the first sampling edge.
- Edge detect:
  - sw_d <= sw_stable every cycle.
  - rise[i] = sw_stable[i] & ~sw_d[i]. This is high for exactly one cycle.
  - Falling edges are ignored.
- Capture:
  - In a cycle where rise[1] is high, on the next edge: Father <= Key_Stable (value in the rise cycle) and Father_Valid <= 1.
  - rise[0] does the same for Mother / Mother_Valid.
  - Both rises in the same cycle: both registers load the same Key_Stable.
  - Recapture overwrites the old value; valid flags stay 1.
- Update: registered; asserted on the same edge the capture registers load, i.e. high during the cycle after the rise, for exactly one cycle per capture event. Simultaneous captures give a single 1-cycle pulse.
- Key change while a switch is held: no capture; the switch must fall and rise again.
- FSM states: EMPTY, FATHER_ONLY, MOTHER_ONLY, COMPLETE.
  - EMPTY -> FATHER_ONLY on rise[1] only.
  - EMPTY -> MOTHER_ONLY on rise[0] only.
  - EMPTY -> COMPLETE on both rises in the same cycle.
  - FATHER_ONLY -> COMPLETE on rise[0].
  - MOTHER_ONLY -> COMPLETE on rise[1].
  - COMPLETE is absorbing until reset.
  - State updates on the same edge as the capture.
  - Both_Valid = (state == COMPLETE), registered/decoded from the state register.
- Switch already high when reset releases: its stable level rises after debounce, and this counts as a normal capture.
- Reset mid-debounce or mid-capture: everything returns to reset values immediately; no partial capture survives.
- Type encoding on Father/Mother/Key_Stable: 00 = O, 10 = A, 01 = B, 11 = AB.

Decomposition:
- Shared package blood_pkg holds:
  - The 2-bit blood-type constants: TYPE_O = 2'b00, TYPE_A = 2'b10, TYPE_B = 2'b01, TYPE_AB = 2'b11.
  - The FSM state encoding: EMPTY = 0, FATHER_ONLY = 1, MOTHER_ONLY = 2, COMPLETE = 3.
- Sub-module blood_debounce: 1-bit synchroniser plus debouncer, parameterised by DEBOUNCE_CYCLES and CNT_W, with output stable. It is instantiated 4 times (2 switches, 2 keys).
- Edge detect, capture registers and FSM stay in the top module.

Test Plan (all scenarios use DEBOUNCE_CYCLES = 4):
- Reset, then idle inputs -> all outputs 0; Update never pulses.
- Key = 2'b10 held, then Switch[1] 0->1 clean -> Father = 2'b10 and Father_Valid = 1 exactly 2+4+1 edges after the switch change. Update pulses one cycle. State FATHER_ONLY; Mother = 0, Both_Valid = 0.
- Switch[0] bounces 0/1 every 2 cycles for 20 cycles, then settles at 1 with Key = 2'b11 -> exactly one capture, Mother = 2'b11. No capture during the bounce.
- Key = 2'b01, Switch raised 0->1 on both bits in the same cycle -> Father = Mother = 2'b01, single Update pulse, EMPTY -> COMPLETE, Both_Valid = 1.
- Father captured as 2'b10, Key changed to 2'b00 while Switch[1] is held -> Father stays 2'b10. Switch[1] falls then rises -> Father = 2'b00, Update pulses.
- Sys_RST asserted asynchronously between clock edges, mid-debounce of Switch[1] -> outputs 0 immediately, before the next edge. After release with Switch[1] still high -> capture occurs after a full debounce.

Source files
------------

// File: rtl/blood_pkg.sv
// Shared definitions for the blood-type parent entry stage: type codes and
// entry-progress state encoding with its transition rule.
package blood_pkg;

  localparam logic [1:0] TYPE_O  = 2'b00;
  localparam logic [1:0] TYPE_A  = 2'b10;
  localparam logic [1:0] TYPE_B  = 2'b01;
  localparam logic [1:0] TYPE_AB = 2'b11;

  typedef enum logic [1:0] {
    EMPTY       = 2'd0,
    FATHER_ONLY = 2'd1,
    MOTHER_ONLY = 2'd2,
    COMPLETE    = 2'd3
  } entry_state_e;

  // rise[1] = father capture, rise[0] = mother capture
  function automatic entry_state_e entry_next(input entry_state_e s, input logic [1:0] rise);
    entry_state_e n;
    n = s;
    case (s)
      EMPTY: begin
        case (rise)
          2'b10:   n = FATHER_ONLY;
          2'b01:   n = MOTHER_ONLY;
          2'b11:   n = COMPLETE;
          default: n = EMPTY;
        endcase
      end
      FATHER_ONLY: n = rise[0] ? COMPLETE : FATHER_ONLY;
      MOTHER_ONLY: n = rise[1] ? COMPLETE : MOTHER_ONLY;
      COMPLETE:    n = COMPLETE;
      default:     n = EMPTY;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/blood_parent_entry_if.sv
// Board-side bus of the parent entry stage: raw switches/keys in, captured
// parent types and status out.
interface blood_parent_entry_if;
  logic [1:0] Switch;
  logic [1:0] Key;
  logic [1:0] Key_Stable;
  logic [1:0] Father;
  logic [1:0] Mother;
  logic       Father_Valid;
  logic       Mother_Valid;
  logic       Both_Valid;
  logic       Update;

  modport master (
    output Switch, Key,
    input  Key_Stable, Father, Mother, Father_Valid, Mother_Valid, Both_Valid, Update
  );

  modport slave (
    input  Switch, Key,
    output Key_Stable, Father, Mother, Father_Valid, Mother_Valid, Both_Valid, Update
  );
endinterface

// File: rtl/blood_debounce.sv
// One raw board input: two-flop synchroniser followed by a debouncer that
// accepts a new level only after it has held for DEBOUNCE_CYCLES cycles.
module blood_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronise, then count consecutive cycles the synced level disagrees
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= CNT_W'(0);
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        cnt_q <= CNT_W'(0);
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync2_q;
        cnt_q    <= CNT_W'(0);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/blood_parent_entry.sv
// Parent entry front end: debounces switches and keys, captures the key
// pattern into Father/Mother on each debounced switch rising edge.
module blood_parent_entry
  import blood_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic                 Sys_CLK,
  input  logic                 Sys_RST,
  blood_parent_entry_if.slave  bus
);

  logic [3:0]   raw_s;
  logic [3:0]   stable_s;
  logic [1:0]   sw_stable_s;
  logic [1:0]   key_stable_s;
  logic [1:0]   rise_s;
  logic [1:0]   sw_d_q;
  logic [1:0]   father_q;
  logic [1:0]   mother_q;
  logic         father_valid_q;
  logic         mother_valid_q;
  logic         update_q;
  logic         both_valid_q;
  entry_state_e state_q;
  entry_state_e state_d;

  assign raw_s = {bus.Switch, bus.Key};

  for (genvar i = 0; i < 4; i++) begin : g_deb
    blood_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk_i    (Sys_CLK),
      .rst_i    (Sys_RST),
      .raw_i    (raw_s[i]),
      .stable_o (stable_s[i])
    );
  end

  assign sw_stable_s  = stable_s[3:2];
  assign key_stable_s = stable_s[1:0];
  assign rise_s       = sw_stable_s & ~sw_d_q;
  assign state_d      = entry_next(state_q, rise_s);

  // Edge history and one-shot capture of the key pattern
  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      sw_d_q         <= 2'b00;
      father_q       <= 2'b00;
      mother_q       <= 2'b00;
      father_valid_q <= 1'b0;
      mother_valid_q <= 1'b0;
      update_q       <= 1'b0;
    end else begin
      sw_d_q   <= sw_stable_s;
      update_q <= |rise_s;
      if (rise_s[1]) begin
        father_q       <= key_stable_s;
        father_valid_q <= 1'b1;
      end
      if (rise_s[0]) begin
        mother_q       <= key_stable_s;
        mother_valid_q <= 1'b1;
      end
    end
  end

  // Entry-progress FSM; Both_Valid tracks the COMPLETE state
  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      state_q      <= EMPTY;
      both_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      both_valid_q <= (state_d == COMPLETE);
    end
  end

  assign bus.Key_Stable   = key_stable_s;
  assign bus.Father       = father_q;
  assign bus.Mother       = mother_q;
  assign bus.Father_Valid = father_valid_q;
  assign bus.Mother_Valid = mother_valid_q;
  assign bus.Both_Valid   = both_valid_q;
  assign bus.Update       = update_q;

endmodule

// File: tb/tb_blood_parent_entry.sv
// Bench for blood_parent_entry: directed scenarios plus random switch/key
// activity, every cycle compared with a behavioural model.
module tb_blood_parent_entry;
  import blood_pkg::*;

  localparam int unsigned DB = 4;
  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  blood_parent_entry_if bus();

  blood_parent_entry #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
    .Sys_CLK (clk),
    .Sys_RST (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_upd    = 0;

  // Model: bits [3:2] = Switch[1:0], [1:0] = Key[1:0]
  logic [3:0] m_p1, m_p2, m_stable;
  logic [3:0] m_win [DB];
  logic [1:0] m_father, m_mother;
  logic       m_fv, m_mv, m_upd, m_pf, m_pm;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_p1 = 4'h0; m_p2 = 4'h0; m_stable = 4'h0;
    for (int k = 0; k < DB; k++) m_win[k] = 4'h0;
    m_father = 2'b00; m_mother = 2'b00;
    m_fv = 1'b0; m_mv = 1'b0; m_upd = 1'b0; m_pf = 1'b0; m_pm = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] old;
    logic       all_diff;
    // capture one cycle after a debounced switch rise
    m_upd = m_pf | m_pm;
    if (m_pf) begin m_father = m_stable[1:0]; m_fv = 1'b1; end
    if (m_pm) begin m_mother = m_stable[1:0]; m_mv = 1'b1; end
    old = m_stable;
    for (int k = DB - 1; k > 0; k--) m_win[k] = m_win[k-1];
    m_win[0] = m_p2;
    // accept a level once the last DB synced samples all disagree
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DB; k++) if (m_win[k][b] === m_stable[b]) all_diff = 1'b0;
      if (all_diff) m_stable[b] = ~m_stable[b];
    end
    m_p2 = m_p1;
    m_p1 = {bus.Switch, bus.Key};
    m_pf = m_stable[3] & ~old[3];
    m_pm = m_stable[2] & ~old[2];
  endtask

  task automatic check_all();
    check_eq("key_stable", 32'(bus.Key_Stable), 32'(m_stable[1:0]));
    check_eq("father", 32'(bus.Father), 32'(m_father));
    check_eq("mother", 32'(bus.Mother), 32'(m_mother));
    check_eq("father_valid", 32'(bus.Father_Valid), 32'(m_fv));
    check_eq("mother_valid", 32'(bus.Mother_Valid), 32'(m_mv));
    check_eq("both_valid", 32'(bus.Both_Valid), 32'(m_fv & m_mv));
    check_eq("update", 32'(bus.Update), 32'(m_upd));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    if (bus.Update) n_upd++;
    check_all();
  endtask

  task automatic do_reset();
    bus.Switch = 2'b00; bus.Key = 2'b00;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (8) tick();
  endtask

  // Called just after a tick: asserts reset between clock edges
  task automatic async_reset();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.Switch = 2'b00;
    bus.Key    = 2'b00;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;

    // idle after reset
    repeat (10) tick();
    check_eq("idle_update_count", 32'(n_upd), 32'd0);
    check_eq("idle_both", 32'(bus.Both_Valid), 32'd0);

    // clean father capture, exact latency
    bus.Key = 2'b10;
    repeat (10) tick();
    n_upd = 0;
    bus.Switch = 2'b10;
    repeat (6) tick();
    check_eq("fv_before_7", 32'(bus.Father_Valid), 32'd0);
    tick();
    check_eq("fv_at_7", 32'(bus.Father_Valid), 32'd1);
    check_eq("father_A", 32'(bus.Father), 32'(TYPE_A));
    check_eq("mother_still_O", 32'(bus.Mother), 32'(TYPE_O));
    check_eq("not_complete", 32'(bus.Both_Valid), 32'd0);
    repeat (3) tick();
    check_eq("father_update_count", 32'(n_upd), 32'd1);

    // mother switch bounces, then settles
    bus.Key = 2'b11;
    repeat (10) tick();
    n_upd = 0;
    for (int i = 0; i < 10; i++) begin
      bus.Switch[0] = ~bus.Switch[0];
      repeat (2) tick();
    end
    check_eq("bounce_no_update", 32'(n_upd), 32'd0);
    check_eq("bounce_mv", 32'(bus.Mother_Valid), 32'd0);
    bus.Switch[0] = 1'b1;
    repeat (10) tick();
    check_eq("bounce_update_count", 32'(n_upd), 32'd1);
    check_eq("mother_AB", 32'(bus.Mother), 32'(TYPE_AB));
    check_eq("complete_after_both", 32'(bus.Both_Valid), 32'd1);

    // simultaneous capture from EMPTY
    do_reset();
    bus.Key = 2'b01;
    repeat (10) tick();
    n_upd = 0;
    bus.Switch = 2'b11;
    repeat (10) tick();
    check_eq("simul_father_B", 32'(bus.Father), 32'(TYPE_B));
    check_eq("simul_mother_B", 32'(bus.Mother), 32'(TYPE_B));
    check_eq("simul_update_count", 32'(n_upd), 32'd1);
    check_eq("simul_complete", 32'(bus.Both_Valid), 32'd1);

    // key change while switch held, then recapture
    do_reset();
    bus.Key = 2'b10;
    repeat (10) tick();
    bus.Switch = 2'b10;
    repeat (10) tick();
    n_upd = 0;
    bus.Key = 2'b00;
    repeat (10) tick();
    check_eq("held_father_A", 32'(bus.Father), 32'(TYPE_A));
    check_eq("held_no_update", 32'(n_upd), 32'd0);
    bus.Switch = 2'b00;
    repeat (10) tick();
    bus.Switch = 2'b10;
    repeat (10) tick();
    check_eq("recap_father_O", 32'(bus.Father), 32'(TYPE_O));
    check_eq("recap_update_count", 32'(n_upd), 32'd1);
    check_eq("recap_fv", 32'(bus.Father_Valid), 32'd1);

    // async reset mid-debounce, switch still high afterwards
    do_reset();
    bus.Key = 2'b10;
    bus.Switch = 2'b10;
    repeat (10) tick();
    bus.Switch = 2'b00;
    repeat (10) tick();
    bus.Switch = 2'b10;
    repeat (3) tick();
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    check_eq("async_fv_zero", 32'(bus.Father_Valid), 32'd0);
    check_eq("async_father_zero", 32'(bus.Father), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();
    check_eq("post_rst_fv_early", 32'(bus.Father_Valid), 32'd0);
    tick();
    check_eq("post_rst_fv", 32'(bus.Father_Valid), 32'd1);
    check_eq("post_rst_father_A", 32'(bus.Father), 32'(TYPE_A));

    // random activity against the model
    do_reset();
    for (int s = 0; s < 80; s++) begin
      bus.Switch = 2'($urandom);
      bus.Key    = 2'($urandom);
      if ($urandom_range(0, 19) == 0) async_reset();
      repeat ($urandom_range(1, 8)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
